// File: rtl/morse_tx_if.sv
// morse_tx_if -- handshake and data bundle for the Morse transmitter.
//   start      : request a transmission (only honoured while idle)
//   stop       : synchronous abort, wins over start
//   pattern    : on/off units, bit length-1 goes out first
//   length     : number of valid units in pattern
//   repeat_en  : keep retransmitting the latched pattern
//   light      : registered Morse output (1 = lit)
//   busy       : transmission or trailing gap in progress
//   done       : one-cycle pulse when a non-repeating transmission ends
interface morse_tx_if #(
   parameter int MAX_UNITS = 16,
   parameter int LEN_W     = 5
);
   logic                 start;
   logic                 stop;
   logic [MAX_UNITS-1:0] pattern;
   logic [LEN_W-1:0]     length;
   logic                 repeat_en;
   logic                 light;
   logic                 busy;
   logic                 done;

   modport master (
      output start, stop, pattern, length, repeat_en,
      input  light, busy, done
   );

   modport slave (
      input  start, stop, pattern, length, repeat_en,
      output light, busy, done
   );
endinterface

// File: rtl/morse_tx.sv
// morse_tx -- sends an on/off unit pattern as Morse light, MSB-of-length first,
// followed by a dark gap; optionally repeats the latched pattern forever.
//   clock  : single clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : morse_tx_if slave (start/stop/pattern/length/repeat_en in,
//            light/busy/done out)
//
// state | meaning
// IDLE  | waiting for start; light, busy low
// SEND  | shifting out pattern units, one per DIV_COUNT cycles
// GAP   | dark trailer of GAP_UNITS units, then repeat or finish
module morse_tx #(
   parameter int DIV_COUNT = 25000000,
   parameter int MAX_UNITS = 16,
   parameter int LEN_W     = 5,
   parameter int GAP_UNITS = 3
) (
   input  logic      clock,
   input  logic      resetn,
   morse_tx_if.slave bus
);
   localparam int DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
   localparam int GAP_W = (GAP_UNITS > 0) ? $clog2(GAP_UNITS + 1) : 1;
   localparam int CNT_W = (LEN_W > GAP_W) ? LEN_W : GAP_W;
   localparam int IDX_W = (MAX_UNITS > 1) ? $clog2(MAX_UNITS) : 1;

   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV_COUNT - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_UNITS);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t               state_q, state_d;
   logic                 light_q, light_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [DIV_W-1:0]     div_q, div_d;
   // Remaining units in the current phase, including the one being sent.
   logic [CNT_W-1:0]     unit_q, unit_d;
   logic [MAX_UNITS-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]     len_q, len_d;

   logic [LEN_W-1:0]     eff_len;
   logic [LEN_W-1:0]     tx_len;
   logic [MAX_UNITS-1:0] tx_pat;
   logic                 tx_go;
   logic                 gap_go;
   logic                 end_go;
   logic                 unit_end;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         light_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         div_q   <= '0;
         unit_q  <= '0;
         pat_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         light_q <= light_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         div_q   <= div_d;
         unit_q  <= unit_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
      end
   end

   // Transitions are resolved in order: the per-state step raises one of
   // tx_go/gap_go/end_go, and the later blocks chain them so that a skipped
   // gap or an immediate repeat still lands in the right state on one edge.
   always_comb begin
      state_d  = state_q;
      light_d  = light_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      div_d    = div_q;
      unit_d   = unit_q;
      pat_d    = pat_q;
      len_d    = len_q;
      tx_go    = 1'b0;
      gap_go   = 1'b0;
      end_go   = 1'b0;
      tx_pat   = pat_q;
      tx_len   = len_q;
      unit_end = (div_q == '0);
      eff_len  = (bus.length > LEN_W'(MAX_UNITS)) ? LEN_W'(MAX_UNITS) : bus.length;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               tx_go  = 1'b1;
               tx_pat = bus.pattern;
               tx_len = eff_len;
               pat_d  = bus.pattern;
               len_d  = eff_len;
            end
         end
         SEND: begin
            if (!unit_end) begin
               div_d = div_q - DIV_W'(1);
            end else if (unit_q == CNT_W'(1)) begin
               gap_go = 1'b1;
            end else begin
               unit_d  = unit_q - CNT_W'(1);
               div_d   = DIV_LOAD;
               light_d = pat_q[IDX_W'(unit_q - CNT_W'(2))];
            end
         end
         GAP: begin
            if (!unit_end) begin
               div_d = div_q - DIV_W'(1);
            end else if (unit_q == CNT_W'(1)) begin
               end_go = 1'b1;
            end else begin
               unit_d = unit_q - CNT_W'(1);
               div_d  = DIV_LOAD;
            end
         end
         default: state_d = IDLE;
      endcase

      if (gap_go) begin
         if (GAP_UNITS == 0) begin
            end_go = 1'b1;
         end else begin
            state_d = GAP;
            light_d = 1'b0;
            div_d   = DIV_LOAD;
            unit_d  = GAP_LOAD;
         end
      end

      // Repeats reuse the latched pattern; the ports are not looked at again.
      if (end_go) begin
         if (bus.repeat_en) begin
            tx_go = 1'b1;
         end else begin
            state_d = IDLE;
            light_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
      end

      if (tx_go) begin
         div_d = DIV_LOAD;
         if (tx_len != '0) begin
            state_d = SEND;
            busy_d  = 1'b1;
            unit_d  = CNT_W'(tx_len);
            light_d = tx_pat[IDX_W'(tx_len - LEN_W'(1))];
         end else if (GAP_UNITS != 0) begin
            state_d = GAP;
            busy_d  = 1'b1;
            light_d = 1'b0;
            unit_d  = GAP_LOAD;
         end else begin
            // Empty pattern with no gap: nothing to send, finish at once.
            state_d = IDLE;
            busy_d  = 1'b0;
            light_d = 1'b0;
            done_d  = 1'b1;
         end
      end

      if (bus.stop) begin
         state_d = IDLE;
         light_d = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         div_d   = '0;
         unit_d  = '0;
         pat_d   = pat_q;
         len_d   = len_q;
      end
   end

   assign bus.light = light_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
endmodule

// File: tb/tb_morse_tx.sv
`timescale 1ns/1ps
module tb_morse_tx;
   localparam int D  = 4;
   localparam int MU = 16;
   localparam int LW = 5;
   localparam int G  = 3;

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   morse_tx_if #(.MAX_UNITS(MU), .LEN_W(LW)) bus ();
   morse_tx_if #(.MAX_UNITS(MU), .LEN_W(LW)) bus0 ();

   morse_tx #(.DIV_COUNT(D), .MAX_UNITS(MU), .LEN_W(LW), .GAP_UNITS(G)) dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus)
   );

   morse_tx #(.DIV_COUNT(D), .MAX_UNITS(MU), .LEN_W(LW), .GAP_UNITS(0)) dut0 (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus0)
   );

   int checks = 0;
   int errors = 0;

   typedef bit bitq_t[$];

   // Expected light, one entry per clock, for a single transmission:
   // each unit held D cycles, most significant valid unit first, then gap.
   function automatic bitq_t build_wave(input logic [MU-1:0] pat, input int len, input int gap);
      bitq_t q;
      int    eff;
      eff = (len > MU) ? MU : len;
      for (int u = 0; u < eff; u++)
         for (int c = 0; c < D; c++)
            q.push_back(pat[eff-1-u]);
      for (int c = 0; c < gap * D; c++)
         q.push_back(1'b0);
      return q;
   endfunction

   // Called at a negedge; returns at the negedge right after acceptance.
   task automatic pulse_start(input logic [MU-1:0] p, input int l);
      bus.pattern = p;
      bus.length  = LW'(l);
      bus.start   = 1'b1;
      @(negedge clock);
      bus.start   = 1'b0;
   endtask

   task automatic test_reset();
      bus.start = 1'b0;  bus.stop = 1'b0;  bus.pattern = '0;  bus.length = '0;  bus.repeat_en = 1'b0;
      bus0.start = 1'b0; bus0.stop = 1'b0; bus0.pattern = '0; bus0.length = '0; bus0.repeat_en = 1'b0;
      #1;
      checks++;
      if (bus.light !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset: light=%b busy=%b done=%b, want 0 0 0", bus.light, bus.busy, bus.done);
      end
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.busy !== 1'b0 || bus0.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: busy=%b busy0=%b done=%b, want 0 0 0", bus.busy, bus0.busy, bus.done);
      end
   endtask

   task automatic test_basic();
      logic [MU-1:0] pats[4];
      int            lens[4];
      bitq_t         q;
      pats[0] = 16'h0005; lens[0] = 3;
      pats[1] = 16'hA5C3; lens[1] = 20;
      pats[2] = 16'hFFFF; lens[2] = 0;
      pats[3] = 16'h0001; lens[3] = 1;
      for (int t = 0; t < 4; t++) begin
         q = build_wave(pats[t], lens[t], G);
         pulse_start(pats[t], lens[t]);
         for (int i = 0; i < q.size(); i++) begin
            checks++;
            if (bus.light !== q[i] || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
               errors++;
               $display("FAIL basic[%0d] cyc %0d: light=%b busy=%b done=%b, want light=%b busy=1 done=0",
                        t, i, bus.light, bus.busy, bus.done, q[i]);
            end
            @(negedge clock);
         end
         checks++;
         if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.light !== 1'b0) begin
            errors++;
            $display("FAIL basic_end[%0d]: busy=%b done=%b light=%b, want 0 1 0", t, bus.busy, bus.done, bus.light);
         end
         @(negedge clock);
         checks++;
         if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width[%0d]: done=%b, want 0", t, bus.done);
         end
      end
   endtask

   task automatic test_random();
      logic [MU-1:0] p;
      int            l;
      bitq_t         q;
      for (int t = 0; t < 8; t++) begin
         p = MU'($urandom);
         l = $urandom_range(0, 20);
         q = build_wave(p, l, G);
         pulse_start(p, l);
         for (int i = 0; i < q.size(); i++) begin
            checks++;
            if (bus.light !== q[i] || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
               errors++;
               $display("FAIL random[%0d] p=%h l=%0d cyc %0d: light=%b busy=%b done=%b, want light=%b busy=1 done=0",
                        t, p, l, i, bus.light, bus.busy, bus.done, q[i]);
            end
            @(negedge clock);
         end
         checks++;
         if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL random_end[%0d]: busy=%b done=%b, want 0 1", t, bus.busy, bus.done);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_start_ignored();
      logic [MU-1:0] p;
      bitq_t         q;
      p = 16'h000B;
      q = build_wave(p, 4, G);
      pulse_start(p, 4);
      for (int i = 0; i < q.size(); i++) begin
         checks++;
         if (bus.light !== q[i] || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored cyc %0d: light=%b busy=%b done=%b, want light=%b busy=1 done=0",
                     i, bus.light, bus.busy, bus.done, q[i]);
         end
         if (i == 5) begin
            bus.start   = 1'b1;
            bus.pattern = ~p;
            bus.length  = LW'(7);
         end
         if (i == 6) bus.start = 1'b0;
         @(negedge clock);
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
         errors++;
         $display("FAIL start_ignored_end: busy=%b done=%b, want 0 1", bus.busy, bus.done);
      end
      @(negedge clock);
   endtask

   task automatic test_repeat();
      logic [MU-1:0] p;
      bitq_t         q;
      p = 16'h0003;
      q = build_wave(p, 2, G);
      bus.repeat_en = 1'b1;
      pulse_start(p, 2);
      for (int i = 0; i < 3 * q.size(); i++) begin
         checks++;
         if (bus.light !== q[i % q.size()] || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL repeat cyc %0d: light=%b busy=%b done=%b, want light=%b busy=1 done=0",
                     i, bus.light, bus.busy, bus.done, q[i % q.size()]);
         end
         if (i == 10) begin
            bus.pattern = '0;
            bus.length  = LW'(5);
         end
         if (i == 45) bus.repeat_en = 1'b0;
         @(negedge clock);
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
         errors++;
         $display("FAIL repeat_end: busy=%b done=%b, want 0 1", bus.busy, bus.done);
      end
      @(negedge clock);
   endtask

   task automatic test_stop();
      logic [MU-1:0] p;
      bitq_t         q;
      int            seen_done;
      p = MU'($urandom) | 16'h0004;
      q = build_wave(p, 6, G);
      pulse_start(p, 6);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (bus.light !== q[i] || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL stop_pre cyc %0d: light=%b busy=%b, want light=%b busy=1", i, bus.light, bus.busy, q[i]);
         end
         if (i < 9) @(negedge clock);
      end
      bus.stop = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.light !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL stop: light=%b busy=%b done=%b, want 0 0 0", bus.light, bus.busy, bus.done);
      end
      bus.start = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.busy !== 1'b0 || bus.light !== 1'b0) begin
         errors++;
         $display("FAIL stop_over_start: busy=%b light=%b, want 0 0", bus.busy, bus.light);
      end
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
         @(negedge clock);
      end
      checks++;
      if (seen_done !== 0) begin
         errors++;
         $display("FAIL stop_quiet: done/busy high for %0d cycles, want 0", seen_done);
      end
   endtask

   task automatic test_reset_mid();
      logic [MU-1:0] p;
      bitq_t         q;
      p = MU'($urandom) | 16'h0010;
      q = build_wave(p, 5, G);
      pulse_start(p, 5);
      repeat (6) @(negedge clock);
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (bus.light !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: light=%b busy=%b done=%b, want 0 0 0", bus.light, bus.busy, bus.done);
      end
      #1 resetn = 1'b1;
      repeat (3) @(negedge clock);
      checks++;
      if (bus.busy !== 1'b0 || bus.light !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_idle: busy=%b light=%b, want 0 0", bus.busy, bus.light);
      end
      pulse_start(p, 5);
      for (int i = 0; i < q.size(); i++) begin
         checks++;
         if (bus.light !== q[i] || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_retx cyc %0d: light=%b busy=%b done=%b, want light=%b busy=1 done=0",
                     i, bus.light, bus.busy, bus.done, q[i]);
         end
         @(negedge clock);
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_end: busy=%b done=%b, want 0 1", bus.busy, bus.done);
      end
      @(negedge clock);
   endtask

   task automatic test_zero_gap();
      logic [MU-1:0] p;
      bitq_t         q;
      bus0.pattern = 16'hFFFF;
      bus0.length  = '0;
      bus0.start   = 1'b1;
      @(negedge clock);
      bus0.start   = 1'b0;
      checks++;
      if (bus0.done !== 1'b1 || bus0.busy !== 1'b0 || bus0.light !== 1'b0) begin
         errors++;
         $display("FAIL zero_len: done=%b busy=%b light=%b, want 1 0 0", bus0.done, bus0.busy, bus0.light);
      end
      @(negedge clock);
      checks++;
      if (bus0.done !== 1'b0 || bus0.busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_len_after: done=%b busy=%b, want 0 0", bus0.done, bus0.busy);
      end
      p = MU'($urandom) | 16'h0002;
      q = build_wave(p, 2, 0);
      bus0.pattern = p;
      bus0.length  = LW'(2);
      bus0.start   = 1'b1;
      @(negedge clock);
      bus0.start   = 1'b0;
      for (int i = 0; i < q.size(); i++) begin
         checks++;
         if (bus0.light !== q[i] || bus0.busy !== 1'b1 || bus0.done !== 1'b0) begin
            errors++;
            $display("FAIL zero_gap cyc %0d: light=%b busy=%b done=%b, want light=%b busy=1 done=0",
                     i, bus0.light, bus0.busy, bus0.done, q[i]);
         end
         @(negedge clock);
      end
      checks++;
      if (bus0.busy !== 1'b0 || bus0.done !== 1'b1 || bus0.light !== 1'b0) begin
         errors++;
         $display("FAIL zero_gap_end: busy=%b done=%b light=%b, want 0 1 0", bus0.busy, bus0.done, bus0.light);
      end
      @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_start_ignored();
      test_repeat();
      test_stop();
      test_reset_mid();
      test_zero_gap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/morse_tx.md
MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 Parameter DIV_COUNT, default 25000000: clock cycles per Morse time unit; legal range is 1 or more.
REQ-002 Parameter MAX_UNITS, default 16: maximum pattern length in units.
REQ-003 Parameter LEN_W, default 5: width of the length port; it SHALL hold the value MAX_UNITS.
REQ-004 Parameter GAP_UNITS, default 3: number of dark units appended after every pattern; legal range is 0 or more.
REQ-005 Port clock, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-006 Port resetn, input, 1: asynchronous, active-low reset.
REQ-007 Port start, input, 1: request transmission; sampled only in IDLE.
REQ-008 Port stop, input, 1: synchronous abort.
REQ-009 Port pattern, input, MAX_UNITS: on/off units to send; bit index length-1 is sent first.
REQ-010 Port length, input, LEN_W: number of valid pattern units.
REQ-011 Port repeat_en, input, 1: when 1, retransmit continuously.
REQ-012 Port light, output, 1: registered Morse output (1 = lit).
REQ-013 Port busy, output, 1: high in SEND and GAP.
REQ-014 Port done, output, 1: one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SEND and GAP.
REQ-016 In IDLE, when start=1 and stop=0 at an edge, the block SHALL:
- latch pattern and eff_len = min(length, MAX_UNITS);
- clear the unit counter and the cycle divider;
- enter SEND.
REQ-017 In SEND, light SHALL equal latched pattern[eff_len-1-u] for unit u, starting with u=0; light and busy SHALL be valid from the edge that accepts start.
REQ-018 Each unit SHALL last exactly DIV_COUNT cycles; the divider SHALL restart at every start and every repeat, so the first unit is never shortened.
REQ-019 After unit eff_len-1 completes, the FSM SHALL enter GAP with light=0 for GAP_UNITS*DIV_COUNT cycles; if GAP_UNITS=0, GAP is skipped.
REQ-020 At the end of GAP, repeat_en is sampled:
- if 1: reload the latched pattern (pattern/length ports are not resampled), enter SEND, no done pulse;
- if 0: enter IDLE, pulse done for 1 cycle, and drop busy on the same edge.
REQ-021 busy SHALL stay high for exactly (eff_len+GAP_UNITS)*DIV_COUNT cycles per non-repeating transmission.
REQ-022 start while busy SHALL be ignored, and changes on pattern, length or repeat_en while busy SHALL have no effect until the next acceptance (except repeat_en sampling per REQ-020).
REQ-023 start with length=0 SHALL skip SEND and go straight to GAP; if GAP_UNITS=0 as well, done SHALL pulse on the next edge.
REQ-024 length greater than MAX_UNITS SHALL be clamped to MAX_UNITS.
REQ-025 stop=1 in any state SHALL, at the next edge, force IDLE with light=0, busy=0 and no done pulse; stop SHALL take priority over simultaneous start.
REQ-026 The divider and unit counters SHALL be sized from DIV_COUNT and LEN_W; there SHALL be no wrap-around inside a unit.

Reset
REQ-027 resetn=0 SHALL immediately, regardless of clock, force:
- state IDLE;
- light=0, busy=0, done=0;
- counters=0;
- latched pattern=0.
REQ-028 Reset asserted mid-transmission SHALL abandon it; after release the block SHALL wait in IDLE for a new start.

Verification (DIV_COUNT=4, MAX_UNITS=16, GAP_UNITS=3)
REQ-029 length=3, pattern=...101, start pulse -> light 1,0,1 for 4 cycles each, then 0 for 12 cycles; busy high 24 cycles; done pulses once at cycle 24.
REQ-030 repeat_en=1, length=2, pattern=...11 -> light sequence 1,1,0,0,0 repeats every 20 cycles with no done; clearing repeat_en during SEND -> done after the current gap.
REQ-031 length=0 with GAP_UNITS=0 (second instance) -> done on the next edge and busy never high; length=20 -> 16 units sent.
REQ-032 start pulsed at cycle 5 of an active transmission -> no effect on light or timing.
REQ-033 stop asserted in unit 2 -> light=0 and busy=0 on the next edge, no done.
REQ-034 resetn pulsed low between clock edges mid-SEND -> outputs 0 immediately; a later start transmits the full pattern with a full-length first unit.
